spart_io_scheduler: RTL and testbench

SPART_IO_SCHEDULER -- requirements
Module: spart_io_scheduler

---
 rtl/spart_io_scheduler.sv | 186 ++++++++++++++++++
 tb/tb_spart_io_scheduler.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spart_io_scheduler.sv
// Drives a SPART register bus: writes the baud divisor once, then polls status and moves RX bytes out and TX FIFO bytes in.
// Bus outputs are registered; requester ready is combinational and drops when the FIFO is full unless a pop frees a slot.
module spart_io_scheduler #(
    parameter logic [15:0] BAUD_DIV   = 16'd325,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic       iocs,
    output logic       iorw,
    output logic [1:0] ioaddr,
    output logic [7:0] io_wdata,
    output logic       io_oe,
    input  logic [7:0] io_rdata,
    input  logic       tx0_valid,
    input  logic [7:0] tx0_data,
    output logic       tx0_ready,
    input  logic       tx1_valid,
    input  logic [7:0] tx1_data,
    output logic       tx1_ready,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    output logic       cfg_done
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    typedef enum logic [2:0] {
        START,
        CFG_LO,
        CFG_HI,
        POLL,
        RX_READ,
        TX_WRITE
    } state_t;

    state_t          state_q, state_d;
    logic            iocs_q, iocs_d;
    logic            iorw_q, iorw_d;
    logic [1:0]      ioaddr_q, ioaddr_d;
    logic [7:0]      io_wdata_q, io_wdata_d;
    logic            cfg_done_q, cfg_done_d;
    logic            rx_valid_q, rx_valid_d;
    logic [7:0]      rx_data_q, rx_data_d;
    logic            last_q, last_d;
    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [7:0]      mem_d [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;

    logic            fifo_empty, fifo_full, pop, can_accept, grant1;
    logic            push0, push1, push;
    logic [7:0]      push_dat;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
    assign pop        = (state_q == TX_WRITE);
    assign can_accept = cfg_done_q & (~fifo_full | pop);

    // With both valid, tx1 wins only when tx0 took the previous slot.
    assign grant1    = tx1_valid & (~tx0_valid | ~last_q);
    assign tx0_ready = can_accept & tx0_valid & ~grant1;
    assign tx1_ready = can_accept & grant1;

    assign push0    = tx0_valid & tx0_ready;
    assign push1    = tx1_valid & tx1_ready;
    assign push     = push0 | push1;
    assign push_dat = push1 ? tx1_data : tx0_data;

    assign iocs     = iocs_q;
    assign iorw     = iorw_q;
    assign ioaddr   = ioaddr_q;
    assign io_wdata = io_wdata_q;
    assign io_oe    = iocs_q & ~iorw_q;
    assign rx_valid = rx_valid_q;
    assign rx_data  = rx_data_q;
    assign cfg_done = cfg_done_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            START:    state_d = CFG_LO;
            CFG_LO:   state_d = CFG_HI;
            CFG_HI:   state_d = POLL;
            POLL: begin
                if (io_rdata[1])
                    state_d = RX_READ;
                else if (io_rdata[0] && !fifo_empty)
                    state_d = TX_WRITE;
            end
            RX_READ:  state_d = POLL;
            TX_WRITE: state_d = POLL;
            default:  state_d = START;
        endcase

        // Bus outputs are decoded from the next state so they line up with it.
        iocs_d     = 1'b0;
        iorw_d     = 1'b1;
        ioaddr_d   = 2'b00;
        io_wdata_d = 8'h00;
        case (state_d)
            CFG_LO: begin
                iocs_d     = 1'b1;
                iorw_d     = 1'b0;
                ioaddr_d   = 2'b10;
                io_wdata_d = BAUD_DIV[7:0];
            end
            CFG_HI: begin
                iocs_d     = 1'b1;
                iorw_d     = 1'b0;
                ioaddr_d   = 2'b11;
                io_wdata_d = BAUD_DIV[15:8];
            end
            POLL: begin
                iocs_d   = 1'b1;
                ioaddr_d = 2'b01;
            end
            RX_READ: begin
                iocs_d = 1'b1;
            end
            TX_WRITE: begin
                iocs_d     = 1'b1;
                iorw_d     = 1'b0;
                io_wdata_d = mem_q[rd_ptr_q];
            end
            default: ;
        endcase

        cfg_done_d = cfg_done_q | (state_q == CFG_HI);
        rx_valid_d = (state_q == RX_READ);
        rx_data_d  = (state_q == RX_READ) ? io_rdata : rx_data_q;

        mem_d = mem_q;
        if (push)
            mem_d[wr_ptr_q] = push_dat;
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop)
            count_d = count_q + CW'(1);
        else if (pop && !push)
            count_d = count_q - CW'(1);

        last_d = last_q;
        if (push1)
            last_d = 1'b1;
        else if (push0)
            last_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= START;
            iocs_q     <= 1'b0;
            iorw_q     <= 1'b1;
            ioaddr_q   <= 2'b00;
            io_wdata_q <= 8'h00;
            cfg_done_q <= 1'b0;
            rx_valid_q <= 1'b0;
            rx_data_q  <= 8'h00;
            last_q     <= 1'b1;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++)
                mem_q[i] <= 8'h00;
        end else begin
            state_q    <= state_d;
            iocs_q     <= iocs_d;
            iorw_q     <= iorw_d;
            ioaddr_q   <= ioaddr_d;
            io_wdata_q <= io_wdata_d;
            cfg_done_q <= cfg_done_d;
            rx_valid_q <= rx_valid_d;
            rx_data_q  <= rx_data_d;
            last_q     <= last_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            mem_q      <= mem_d;
        end
    end

endmodule

// File: tb/tb_spart_io_scheduler.sv
// Bench for spart_io_scheduler: a behavioural SPART/requester model predicts every bus cycle, ready and RX result.
module tb_spart_io_scheduler;

    localparam int          DEPTH = 4;
    localparam logic [15:0] BAUD  = 16'd325;

    localparam int OP_IDLE = 0;
    localparam int OP_POLL = 1;
    localparam int OP_RX   = 2;
    localparam int OP_TX   = 3;
    localparam int OP_CLO  = 4;
    localparam int OP_CHI  = 5;
    localparam int OP_BAD  = 6;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       iocs, iorw, io_oe;
    logic [1:0] ioaddr;
    logic [7:0] io_wdata, io_rdata;
    logic       tx0_valid = 1'b0, tx1_valid = 1'b0;
    logic [7:0] tx0_data = 8'h00, tx1_data = 8'h00;
    logic       tx0_ready, tx1_ready;
    logic       rx_valid, cfg_done;
    logic [7:0] rx_data;

    logic [7:0] status_reg = 8'h00;
    logic [7:0] data_reg   = 8'h00;

    assign io_rdata = (ioaddr == 2'b01) ? status_reg : data_reg;

    always #5 clk = ~clk;

    spart_io_scheduler #(.BAUD_DIV(BAUD), .FIFO_DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .iocs      (iocs),
        .iorw      (iorw),
        .ioaddr    (ioaddr),
        .io_wdata  (io_wdata),
        .io_oe     (io_oe),
        .io_rdata  (io_rdata),
        .tx0_valid (tx0_valid),
        .tx0_data  (tx0_data),
        .tx0_ready (tx0_ready),
        .tx1_valid (tx1_valid),
        .tx1_data  (tx1_data),
        .tx1_ready (tx1_ready),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .cfg_done  (cfg_done)
    );

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [7:0] fifo_m[$];
    logic [7:0] log_m[$];
    bit         last_m;
    int         k;
    int         prev_op;
    logic [7:0] prev_status;
    int         prev_cnt;
    bit         rx_pend;
    logic [7:0] rx_hold;
    bit         acc0, acc1;
    bit         keep;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int decode_op();
        if (!iocs)
            return (iorw && ioaddr == 2'b00 && io_wdata == 8'h00) ? OP_IDLE : OP_BAD;
        if (iorw) begin
            if (io_wdata != 8'h00) return OP_BAD;
            if (ioaddr == 2'b01) return OP_POLL;
            if (ioaddr == 2'b00) return OP_RX;
            return OP_BAD;
        end
        case (ioaddr)
            2'b00:   return OP_TX;
            2'b10:   return OP_CLO;
            2'b11:   return OP_CHI;
            default: return OP_BAD;
        endcase
    endfunction

    task automatic model_reset();
        fifo_m.delete();
        last_m  = 1'b1;
        k       = 0;
        prev_op = OP_IDLE;
        rx_pend = 1'b0;
        rx_hold = 8'h00;
        acc0    = 1'b0;
        acc1    = 1'b0;
    endtask

    // Called at a falling edge with inputs already set; checks this cycle, then advances the model.
    task automatic tick();
        int exp_op;
        int win;
        bit base;
        bit er0, er1;
        #1;
        if (k == 0)      exp_op = OP_IDLE;
        else if (k == 1) exp_op = OP_CLO;
        else if (k == 2) exp_op = OP_CHI;
        else if (prev_op == OP_POLL) begin
            if (prev_status[1])                      exp_op = OP_RX;
            else if (prev_status[0] && prev_cnt > 0) exp_op = OP_TX;
            else                                     exp_op = OP_POLL;
        end else
            exp_op = OP_POLL;

        check_val("bus_op", decode_op(), exp_op);
        if (exp_op == OP_CLO) check_val("cfg_lo_data", io_wdata, BAUD[7:0]);
        if (exp_op == OP_CHI) check_val("cfg_hi_data", io_wdata, BAUD[15:8]);
        if (exp_op == OP_TX && fifo_m.size() > 0) check_val("tx_wdata", io_wdata, fifo_m[0]);
        check_val("io_oe", io_oe, (exp_op == OP_TX || exp_op == OP_CLO || exp_op == OP_CHI));
        check_val("cfg_done", cfg_done, (k >= 3));
        check_val("rx_valid", rx_valid, rx_pend);
        check_val("rx_data", rx_data, rx_hold);

        base = (k >= 3) && (fifo_m.size() < DEPTH || exp_op == OP_TX);
        if (tx0_valid && tx1_valid) win = last_m ? 0 : 1;
        else if (tx0_valid)         win = 0;
        else if (tx1_valid)         win = 1;
        else                        win = -1;
        er0 = base && (win == 0);
        er1 = base && (win == 1);
        check_val("tx0_ready", tx0_ready, er0);
        check_val("tx1_ready", tx1_ready, er1);

        prev_cnt    = fifo_m.size();
        prev_status = status_reg;
        prev_op     = exp_op;
        if (exp_op == OP_TX && fifo_m.size() > 0) void'(fifo_m.pop_front());
        if (er0) begin fifo_m.push_back(tx0_data); last_m = 1'b0; end
        if (er1) begin fifo_m.push_back(tx1_data); last_m = 1'b1; end
        acc0    = er0;
        acc1    = er1;
        rx_pend = (exp_op == OP_RX);
        if (exp_op == OP_RX) rx_hold = data_reg;
        k++;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Continuous requesters: on acceptance, log the byte and present the next one.
    task automatic tick_log();
        tick();
        if (acc0) begin
            log_m.push_back(tx0_data);
            tx0_data  = tx0_data + 8'd1;
            tx0_valid = keep;
        end
        if (acc1) begin
            log_m.push_back(tx1_data);
            tx1_data  = tx1_data + 8'd1;
            tx1_valid = keep;
        end
    endtask

    task automatic drive_rand();
        status_reg    = 8'($urandom);
        status_reg[0] = ($urandom_range(0, 99) < 40);
        status_reg[1] = ($urandom_range(0, 99) < 15);
        data_reg      = 8'($urandom);
        if (!tx0_valid || acc0) begin
            tx0_valid = ($urandom_range(0, 99) < 55);
            tx0_data  = 8'($urandom);
        end
        if (!tx1_valid || acc1) begin
            tx1_valid = ($urandom_range(0, 99) < 55);
            tx1_data  = 8'($urandom);
        end
    endtask

    task automatic check_reset_outputs(input string pfx);
        check_val({pfx, "_iocs"}, iocs, 1'b0);
        check_val({pfx, "_iorw"}, iorw, 1'b1);
        check_val({pfx, "_io_oe"}, io_oe, 1'b0);
        check_val({pfx, "_tx0_ready"}, tx0_ready, 1'b0);
        check_val({pfx, "_tx1_ready"}, tx1_ready, 1'b0);
        check_val({pfx, "_rx_valid"}, rx_valid, 1'b0);
        check_val({pfx, "_rx_data"}, rx_data, 8'h00);
        check_val({pfx, "_cfg_done"}, cfg_done, 1'b0);
    endtask

    initial begin
        logic [7:0] exp_log [6];
        exp_log[0] = 8'hA0; exp_log[1] = 8'hB0; exp_log[2] = 8'hA1;
        exp_log[3] = 8'hB1; exp_log[4] = 8'hA2; exp_log[5] = 8'hB2;

        // Power-on reset with both requesters already valid
        tx0_valid = 1'b1; tx0_data = 8'hA0;
        tx1_valid = 1'b1; tx1_data = 8'hB0;
        keep = 1'b1;
        @(negedge clk);
        #1;
        check_reset_outputs("por");
        @(negedge clk);
        model_reset();
        rst_n = 1'b1;

        // Configuration, then alternating fill until full
        repeat (9) tick_log();
        check_val("rr_fill_count", log_m.size(), 4);

        // Full FIFO: each pop admits exactly one new byte, arbitration keeps alternating
        repeat (2) begin
            status_reg = 8'h01;
            tick_log();
            status_reg = 8'h00;
            repeat (3) tick_log();
        end
        check_val("rr_total_count", log_m.size(), 6);
        for (int i = 0; i < 6; i++)
            if (i < log_m.size()) check_val($sformatf("rr_order%0d", i), log_m[i], exp_log[i]);

        // Drain everything; leftover requests drop once accepted
        keep = 1'b0;
        status_reg = 8'h01;
        repeat (24) tick_log();

        // Single push then single write; FIFO must be empty afterwards
        status_reg = 8'h00;
        tx0_valid = 1'b1; tx0_data = 8'h11;
        repeat (3) begin
            tick();
            if (acc0) tx0_valid = 1'b0;
        end
        status_reg = 8'h01;
        repeat (5) tick();

        // Receive one byte
        status_reg = 8'h02; data_reg = 8'hA5;
        tick();
        status_reg = 8'h00;
        repeat (3) tick();
        check_val("rx_a5", rx_data, 8'hA5);

        // RX takes priority over a pending TX
        tx0_valid = 1'b1; tx0_data = 8'hC3;
        tick();
        if (acc0) tx0_valid = 1'b0;
        status_reg = 8'h03; data_reg = 8'h5A;
        tick();
        status_reg = 8'h01;
        repeat (4) tick();
        check_val("rx_5a", rx_data, 8'h5A);

        // Randomised traffic
        repeat (1500) begin
            drive_rand();
            tick();
        end

        // Asynchronous reset mid-traffic discards the FIFO and restarts configuration
        tx0_valid = 1'b1; tx1_valid = 1'b1;
        status_reg = 8'h00;
        tick();
        #7;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mid");
        @(negedge clk);
        @(negedge clk);
        model_reset();
        tx0_valid = 1'b0; tx1_valid = 1'b0;
        status_reg = 8'h01;
        rst_n = 1'b1;
        repeat (8) tick();

        repeat (1500) begin
            drive_rand();
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
